// File: rtl/button_event.sv
// button_event: turns a debounced, synchronous button level into one-cycle
// press / release / long-press events, with a level "held" flag.
// Optional auto-repeat after a long press is enabled by defining the macro
// BUTTON_EVENT_REPEAT_EN. Without it, o_repeat_pulse is tied to 0.
// Event outputs are plain one-cycle strobes with no valid/ready handshake.
// The consumer must sample them on every clock edge.
// o_state exposes the FSM state: 0 IDLE, 1 PRESSED, 2 LONG, 3 LOCKOUT.
module button_event #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_in,
  input  logic       i_enable,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long_press,
  output logic       o_repeat_pulse,
  output logic       o_held,
  output logic [1:0] o_state
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rst_seen;  // first edge after reset: a high input must not be taken as a press
  logic          r_press;
  logic          r_release;
  logic          r_long_press;
  logic          r_repeat_pulse;
  logic          r_held;
  logic [CW-1:0] w_cnt_inc;

  // The counter saturates at all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

  // Main FSM. All outputs are registered, and pulses are cleared by default every cycle.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_rst_seen     <= 1'b1;
      r_press        <= 1'b0;
      r_release      <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat_pulse <= 1'b0;
      r_held         <= 1'b0;
    end else begin
      r_rst_seen     <= 1'b0;
      r_press        <= 1'b0;
      r_release      <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_held <= 1'b0;
          if (i_in) begin
            if (i_enable && !r_rst_seen) begin
              r_state <= PRESSED;
              r_press <= 1'b1;
              r_held  <= 1'b1;
              r_cnt   <= CW'(1);
            end else begin
              r_state <= LOCKOUT;
            end
          end
        end
        PRESSED: begin
          if (!i_enable) begin
            r_state <= LOCKOUT;
            r_held  <= 1'b0;
            r_cnt   <= '0;
          end else if (!i_in) begin
            // Release takes priority over reaching the long-press threshold.
            r_state   <= IDLE;
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_cnt     <= '0;
          end else if (r_cnt == CW'(LONG_CYCLES - 1)) begin
            r_state      <= LONG;
            r_long_press <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        LONG: begin
          if (!i_enable) begin
            r_state <= LOCKOUT;
            r_held  <= 1'b0;
            r_cnt   <= '0;
          end else if (!i_in) begin
            // Release takes priority over a repeat that falls due on the same edge.
            r_state   <= IDLE;
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_cnt     <= '0;
          end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
            if (r_cnt == CW'(REPEAT_CYCLES - 1)) begin
              r_repeat_pulse <= 1'b1;
              r_cnt          <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
`else
            r_cnt <= '0;
`endif
          end
        end
        LOCKOUT: begin
          r_held <= 1'b0;
          r_cnt  <= '0;
          if (!i_in) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_held  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_press        = r_press;
  assign o_release      = r_release;
  assign o_long_press   = r_long_press;
  assign o_repeat_pulse = r_repeat_pulse;
  assign o_held         = r_held;
  assign o_state        = r_state;

endmodule

// File: tb/tb_button_event.sv
// Directed testbench for button_event with LONG_CYCLES=8 and REPEAT_CYCLES=4.
// The observed outputs are packed as {press, release, long_press, repeat_pulse, held}.
module tb_button_event;

  localparam int LONG_CYCLES   = 8;
  localparam int REPEAT_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn;
  logic       in_lvl;
  logic       enable;
  logic       press;
  logic       rel;
  logic       long_press;
  logic       repeat_pulse;
  logic       held;
  logic [1:0] state;

  always #5 clk = ~clk;

  button_event #(
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_in           (in_lvl),
    .i_enable       (enable),
    .o_press        (press),
    .o_release      (rel),
    .o_long_press   (long_press),
    .o_repeat_pulse (repeat_pulse),
    .o_held         (held),
    .o_state        (state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive the inputs, then step to just after the next rising edge.
  task automatic tick(input logic rst_n, input logic lvl, input logic en);
    resetn = rst_n;
    in_lvl = lvl;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic [4:0] exp_v);
    check(tag, {3'b000, press, rel, long_press, repeat_pulse, held}, {3'b000, exp_v});
  endtask

  task automatic expect_state(input string tag, input logic [1:0] exp_v);
    check(tag, {6'd0, state}, {6'd0, exp_v});
  endtask

  logic [4:0] e;

  initial begin
    resetn = 1'b0;
    in_lvl = 1'b0;
    enable = 1'b1;

    // Test 1: reset, then a short press with no long press.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);
    expect_outs("t1_reset_outs", 5'b00000);
    expect_state("t1_reset_state", 2'd0);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t1_idle", 5'b00000);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t1_press", 5'b10001);
    expect_state("t1_pressed_state", 2'd1);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t1_held_a", 5'b00001);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t1_held_b", 5'b00001);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t1_release", 5'b01000);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t1_after", 5'b00000);

    // Tests 2 and 3: hold for 30 cycles. Long press comes at t+7.
    // With the repeat macro defined, repeats come at t+11, t+15, and so on.
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t2_press", 5'b10001);
    for (int j = 1; j < 30; j++) begin
      tick(1'b1, 1'b1, 1'b1);
      e = 5'b00001;
      if (j == 7) e = 5'b00101;
`ifdef BUTTON_EVENT_REPEAT_EN
      if (j > 7 && ((j - 7) % REPEAT_CYCLES) == 0) e = 5'b00011;
`endif
      expect_outs($sformatf("t2_hold_%0d", j), e);
    end
    expect_state("t2_long_state", 2'd2);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t2_release", 5'b01000);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t2_after", 5'b00000);

    // Test 4: the input falls on the edge where the count reaches LONG_CYCLES-1.
    // Release must win and no long press is seen.
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t4_press", 5'b10001);
    for (int j = 1; j < LONG_CYCLES - 1; j++) begin
      tick(1'b1, 1'b1, 1'b1);
      expect_outs($sformatf("t4_hold_%0d", j), 5'b00001);
    end
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t4_release_wins", 5'b01000);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t4_after", 5'b00000);

    // Test 5: drop enable mid-hold, then raise it again while the input is still high.
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t5_press", 5'b10001);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    expect_outs("t5_disable", 5'b00000);
    expect_state("t5_lockout_state", 2'd3);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t5_reenable_a", 5'b00000);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t5_reenable_b", 5'b00000);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t5_unlock", 5'b00000);
    expect_state("t5_idle_state", 2'd0);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t5_repress", 5'b10001);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t5_release", 5'b01000);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t5_after", 5'b00000);

    // Test 6: input high through reset, then a reset asserted while in LONG.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    expect_outs("t6_reset_in_high", 5'b00000);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t6_first_edge", 5'b00000);
    expect_state("t6_lockout_state", 2'd3);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t6_still_locked", 5'b00000);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t6_unlock", 5'b00000);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t6_press", 5'b10001);
    for (int j = 1; j < LONG_CYCLES - 1; j++) tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t6_long", 5'b00101);
    tick(1'b1, 1'b1, 1'b1);
    expect_outs("t6_in_long", 5'b00001);
    tick(1'b0, 1'b1, 1'b1);
    expect_outs("t6_reset_mid_long", 5'b00000);
    expect_state("t6_reset_state", 2'd0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t6_no_release_a", 5'b00000);
    tick(1'b1, 1'b0, 1'b1);
    expect_outs("t6_no_release_b", 5'b00000);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
